ung_stream_arbiter: RTL and testbench
=====================================

Name: ung_stream_arbiter

Overview:
- Shares one unary bit-stream generator among NREQ requesters using round-robin arbitration.
- Each grant latches the winner's WIDTH-bit binary value.
- The block then emits one fixed-length unary frame: v ones followed by zeros, length L = 2^WIDTH-1 cycles.
- It sits between the binary operand sources and the downstream stochastic/unary arithmetic, which consumes bit_out with its frame markers.

Parameters:
WIDTH, 5, binary precision m; frame length L = 2^WIDTH-1 cycles
NREQ, 4, number of requesters (>=2, need not be a power of two)
IDW, 2, owner-index width, = ceil(log2(NREQ))

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req  input  NREQ  per-requester request; held high with data until ack
data_in  input  NREQ*WIDTH  requester i's value in bits [i*WIDTH +: WIDTH]
ack  output  NREQ  one-cycle pulse to the granted requester
bit_out  output  1  unary stream bit
bit_valid  output  1  high for every cycle of a frame
sof  output  1  high on the first cycle of a frame
eof  output  1  high on the last (L-th) cycle of a frame
owner  output  IDW  index of the requester whose frame is on bit_out
busy  output  1  high while state is not IDLE

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, rr pointer 0, value 0, frame counter 0, ack 0, bit_out 0, bit_valid 0, sof 0, eof 0, owner 0, busy 0.
- FSM has two states: IDLE and RUN.
- IDLE, at an edge where any req is high:
  - Search requesters starting at the rr pointer, ascending with wrap; the first one with req high wins (w).
  - At that same edge register: ack[w]=1, owner=w, rr pointer = (w+1) mod NREQ, value = data_in[w]-1 if data_in[w]!=0 else 0.
  - Also register: bit_out = (data_in[w]!=0), bit_valid=1, sof=1, frame counter=1, state=RUN.
  - First stream bit and ack therefore appear in the cycle after req is sampled (latency 1).
- IDLE with no req: outputs stay 0, pointer unchanged.
- RUN, each edge:
  - ack=0, sof=0.
  - bit_out = (value!=0); value decrements when nonzero and saturates at 0 (never wraps).
  - counter increments.
  - When the counter reaches L: that cycle carries eof=1.
  - At the following edge: state=IDLE, bit_valid=0, eof=0, bit_out=0.
- Frame content: exactly v ones then L-v zeros, where v = latched value. v=0 gives all zeros; v=L gives all ones.
- Requests are not sampled in RUN. At least one IDLE cycle separates consecutive frames, so period = L+1 cycles under continuous load.
- Requesters deassert req on seeing ack. req still high in the cycle after ack is not a new request, because the block is in RUN.
- owner and busy are stable for the whole frame; owner holds its last value in IDLE.
- Round robin: with all requesters continuously requesting, grants go 0,1,...,NREQ-1,0,... For non-power-of-two NREQ the pointer wraps at NREQ.
- Reset mid-frame: the frame is aborted at the next edge. No eof is produced, the pointer returns to 0, and there is no residual ack.
- req bits at index >= NREQ do not exist; data_in of non-requesting indices is ignored.

Test Plan:
1. WIDTH=5, after reset req[0]=1 with data 3 -> next cycle ack[0]=1 and sof=1; 31 bit_valid cycles with bits 1,1,1 then 28 zeros; eof on the 31st; owner=0; busy falls one cycle after eof.
2. Single requests with values 0 then 31 -> the first frame is 31 zeros, the second is 31 ones; each count of ones is verified.
3. All four req high simultaneously after reset with values 1,2,3,4 -> frames for owners 0,1,2,3 in order, each containing 1/2/3/4 ones; each request's ack is followed by deassertion; 32-cycle period.
4. req[0] and req[2] held continuously (re-requesting after ack) -> owners alternate 0,2,0,2; req[1]/req[3] never acked.
5. req[3] asserted at cycle 5 of owner 1's frame -> no ack until the frame ends; ack[3] arrives in the cycle after the first IDLE cycle.
6. rst asserted on frame cycle 10 -> next cycle all outputs 0 with no eof; a new req[2] is then granted normally with pointer restarted from 0.

Source files
------------

// File: rtl/ung_stream_arbiter.sv
// Round-robin arbiter sharing one unary bit-stream generator.
// Each grant emits a fixed L = 2^WIDTH-1 cycle frame: v ones, then zeros.
module ung_stream_arbiter #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       ack,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  sof,
    output logic                  eof,
    output logic [IDW-1:0]        owner,
    output logic                  busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [WIDTH-1:0] LEN    = '1;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] LEN_M1 = LEN - ONE;
    localparam logic [IDW-1:0]   LAST   = IDW'(NREQ - 1);

    logic [0:0]       state;
    logic [IDW-1:0]   rr_ptr;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] cnt;

    logic             any_req;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   win_nxt;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] win_val;
    logic [NREQ-1:0]  win_onehot;
    int               idx;

    // Pick the first requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!any_req && idx == i && req[i]) begin
                    any_req = 1'b1;
                    win     = IDW'(i);
                end
            end
        end
    end

    // Winner's operand, next pointer and one-hot grant.
    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_data      = data_in[i*WIDTH +: WIDTH];
                win_onehot[i] = 1'b1;
            end
        end
        win_nxt = (win == LAST) ? '0 : win + 1'b1;
        win_val = (win_data != '0) ? win_data - ONE : '0;
    end

    // Grant in IDLE, then stream the unary frame in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            value     <= '0;
            cnt       <= '0;
            ack       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            owner     <= '0;
            busy      <= 1'b0;
        end else begin
            ack <= '0;
            sof <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        ack       <= win_onehot;
                        owner     <= win;
                        rr_ptr    <= win_nxt;
                        value     <= win_val;
                        bit_out   <= (win_data != '0);
                        bit_valid <= 1'b1;
                        sof       <= 1'b1;
                        eof       <= (LEN == ONE);
                        cnt       <= ONE;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == LEN) begin
                        state     <= IDLE;
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b0;
                        eof       <= 1'b0;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        value     <= '0;
                    end else begin
                        bit_out <= (value != '0);
                        if (value != '0) begin
                            value <= value - ONE;
                        end
                        cnt <= cnt + ONE;
                        eof <= (cnt == LEN_M1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ung_stream_arbiter.sv
// Bench for ung_stream_arbiter: directed scenarios plus random traffic,
// every cycle compared with a frame-position reference model.
module tb_ung_stream_arbiter;

    localparam int W    = 5;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int L    = (1 << W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*W-1:0]   data_in = '0;
    logic [NREQ-1:0]     ack;
    logic                bit_out;
    logic                bit_valid;
    logic                sof;
    logic                eof;
    logic [IDW-1:0]      owner;
    logic                busy;

    logic [NREQ-1:0]     rereq = '0;
    logic [10:0]         dut_vec;

    int checks = 0;
    int errors = 0;

    // reference model: frame position 1..L, latched value, rotating pointer
    bit m_on    = 1'b0;
    int m_pos   = 0;
    int m_v     = 0;
    int m_rr    = 0;
    int m_owner = 0;

    ung_stream_arbiter #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .data_in(data_in),
        .ack(ack),
        .bit_out(bit_out),
        .bit_valid(bit_valid),
        .sof(sof),
        .eof(eof),
        .owner(owner),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign dut_vec = {ack, bit_out, bit_valid, sof, eof, owner, busy};

    function automatic logic [10:0] exp_vec();
        logic [NREQ-1:0] a;
        logic            first;
        a     = '0;
        first = m_on && (m_pos == 1);
        if (first) a = NREQ'(1) << m_owner;
        return {a, 1'(m_on && m_pos <= m_v), 1'(m_on), 1'(first),
                1'(m_on && m_pos == L), IDW'(m_owner), 1'(m_on)};
    endfunction

    task automatic model_step();
        int i;
        if (rst) begin
            m_on = 1'b0; m_pos = 0; m_v = 0; m_rr = 0; m_owner = 0;
        end else if (m_on) begin
            if (m_pos == L) begin
                m_on  = 1'b0;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_rr + k) % NREQ;
                if (!m_on && req[i]) begin
                    m_on    = 1'b1;
                    m_pos   = 1;
                    m_owner = i;
                    m_v     = int'(data_in[i*W +: W]);
                    m_rr    = (i + 1) % NREQ;
                end
            end
        end
    endtask

    // one clock: model follows the edge, requesters react at negedge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                req[i] = 1'b0;
            end else if (rereq[i] && !req[i]) begin
                req[i] = 1'b1;
                data_in[i*W +: W] = W'($urandom_range(0, L));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        rereq = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        data_in = 20'($urandom);
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (dut_vec !== '0 || exp_vec() !== '0) begin
                errors++;
                $display("FAIL reset_hold t=%0d got %b exp 0", t, dut_vec);
            end
        end
        rst = 1'b0;
        req = '0;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (dut_vec !== '0) begin
                errors++;
                $display("FAIL reset_idle t=%0d got %b exp 0", t, dut_vec);
            end
        end
    endtask

    task automatic test_single();
        int ones, valid, eof_at, pos;
        do_reset();
        ones = 0; valid = 0; eof_at = -1; pos = 0;
        data_in = 20'($urandom);
        data_in[0 +: W] = W'(3);
        req = 4'b0001;
        for (int t = 1; t <= 36; t++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL single t=%0d got %b exp %b", t, dut_vec, exp_vec());
            end
            if (bit_valid) begin
                pos++;
                valid++;
                if (bit_out) ones++;
                if (eof) eof_at = pos;
            end
        end
        checks++;
        if (ones !== 3 || valid !== L || eof_at !== L) begin
            errors++;
            $display("FAIL single_frame got ones=%0d len=%0d eof@%0d exp 3 %0d %0d",
                     ones, valid, eof_at, L, L);
        end
    endtask

    task automatic test_extremes();
        int ones;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            ones = 0;
            data_in = 20'($urandom);
            data_in[(f+1)*W +: W] = (f == 0) ? W'(0) : W'(L);
            req = NREQ'(1) << (f + 1);
            for (int t = 1; t <= 34; t++) begin
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL extreme f=%0d t=%0d got %b exp %b",
                             f, t, dut_vec, exp_vec());
                end
                if (bit_valid && bit_out) ones++;
            end
            checks++;
            if (ones !== ((f == 0) ? 0 : L)) begin
                errors++;
                $display("FAIL extreme_ones f=%0d got %0d exp %0d",
                         f, ones, (f == 0) ? 0 : L);
            end
        end
    endtask

    task automatic test_all_four();
        int nf, last_sof;
        int own[4];
        int ones[4];
        int per[4];
        do_reset();
        nf = 0; last_sof = 0;
        for (int i = 0; i < 4; i++) begin
            own[i] = -1; ones[i] = 0; per[i] = 0;
            data_in[i*W +: W] = W'(i + 1);
        end
        req = 4'b1111;
        for (int t = 1; t <= 4 * (L + 1) + 3; t++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL all4 t=%0d got %b exp %b", t, dut_vec, exp_vec());
            end
            if (sof && nf < 4) begin
                own[nf] = int'(owner);
                per[nf] = t - last_sof;
                last_sof = t;
                nf++;
            end
            if (bit_valid && bit_out && nf > 0) ones[nf-1]++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (own[i] !== i || ones[i] !== i + 1
                || (i > 0 && per[i] !== L + 1)) begin
                errors++;
                $display("FAIL all4_frame %0d got own=%0d ones=%0d per=%0d exp %0d %0d %0d",
                         i, own[i], ones[i], per[i], i, i + 1, L + 1);
            end
        end
        checks++;
        if (req !== '0) begin
            errors++;
            $display("FAIL all4_acked got req=%b exp 0000", req);
        end
    endtask

    task automatic test_alternate();
        int nf;
        int own[4];
        logic [NREQ-1:0] seen;
        do_reset();
        nf = 0;
        seen = '0;
        for (int i = 0; i < 4; i++) own[i] = -1;
        data_in = 20'($urandom);
        req = 4'b0101;
        rereq = 4'b0101;
        for (int t = 1; t <= 4 * (L + 1) + 3; t++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL alt t=%0d got %b exp %b", t, dut_vec, exp_vec());
            end
            seen = seen | ack;
            if (sof && nf < 4) begin
                own[nf] = int'(owner);
                nf++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (own[i] !== ((i % 2) * 2)) begin
                errors++;
                $display("FAIL alt_owner %0d got %0d exp %0d", i, own[i], (i % 2) * 2);
            end
        end
        checks++;
        if (seen !== 4'b0101) begin
            errors++;
            $display("FAIL alt_acks got %b exp 0101", seen);
        end
        rereq = '0;
        req = '0;
        for (int t = 0; t < L + 2; t++) tick();
    endtask

    task automatic test_late();
        int ack3_at;
        do_reset();
        ack3_at = -1;
        data_in = 20'($urandom);
        req = 4'b0010;
        for (int t = 1; t <= 70; t++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL late t=%0d got %b exp %b", t, dut_vec, exp_vec());
            end
            if (ack[3] && ack3_at < 0) ack3_at = t;
            if (t == 5) req[3] = 1'b1;
        end
        checks++;
        if (ack3_at !== L + 2) begin
            errors++;
            $display("FAIL late_ack3 got t=%0d exp t=%0d", ack3_at, L + 2);
        end
    endtask

    task automatic test_reset_mid();
        int eofs;
        do_reset();
        eofs = 0;
        data_in = 20'($urandom);
        req = 4'b0010;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (eof) eofs++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dut_vec !== '0 || eofs !== 0) begin
            errors++;
            $display("FAIL mid_reset got %b eofs=%0d exp 0 0", dut_vec, eofs);
        end
        req = 4'b0101;
        tick();
        checks++;
        if (ack !== 4'b0001 || owner !== '0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL mid_regrant got ack=%b owner=%0d exp ack=0001 owner=0",
                     ack, owner);
        end
        for (int t = 0; t < 2 * (L + 1) + 2; t++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL mid_after t=%0d got %b exp %b", t, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    case ($urandom_range(0, 3))
                        0: data_in[i*W +: W] = W'(0);
                        1: data_in[i*W +: W] = W'(L);
                        default: data_in[i*W +: W] = W'($urandom_range(0, L));
                    endcase
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
            rst = 1'b0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random t=%0d got %b exp %b", t, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_all_four();
        test_alternate();
        test_late();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
